// File: rtl/prog_loader_pkg.sv
// Shared constants and types for the program loader and the program-memory fetch side.
package prog_loader_pkg;

  localparam int unsigned PROG_ADDR_W = 12;
  localparam int unsigned PROG_DATA_W = 8;
  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_HI,
    LD_LEN_LO,
    LD_DATA,
    LD_CSUM
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic int unsigned baud_div(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Program memory write port: driven by the loader, consumed by the RAM.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic                   we;
  logic [PROG_ADDR_W-1:0] addr;
  logic [PROG_DATA_W-1:0] din;

  modport master (output we, addr, din);
  modport slave  (input  we, addr, din);

endinterface

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: input synchroniser, mid-bit sampling, one-cycle valid / framing-error pulses.
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int unsigned FREQ = 27_000_000,
  parameter int unsigned BAUD = 115_200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_frame_err
);

  localparam int unsigned DIV  = baud_div(FREQ, BAUD);
  localparam int unsigned CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'((DIV - 1) / 2);

  logic [1:0]    sync_q;
  logic          prev_q;
  logic          rx_s;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  // Synchroniser and edge history reset to the idle-high line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], i_rx};
      prev_q <= sync_q[1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Half a bit in: a high line means the falling edge was a glitch.
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = rx_s;
          ferr_d  = !rx_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign o_valid     = valid_q;
  assign o_data      = shift_q;
  assign o_frame_err = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// Receives a framed program image over UART (A5, LEN_HI, LEN_LO, data, CSUM) and writes it into program RAM.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned FREQ       = 27_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned TIMEOUT_MS = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_rx,
  prog_loader_if.master          o_mem,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic [PROG_ADDR_W-1:0] o_count
);

  localparam int unsigned TMO_CYC = TIMEOUT_MS * FREQ / 1000;
  localparam int unsigned TW      = $clog2(TMO_CYC + 1);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;

  uart_rx #(.FREQ(FREQ), .BAUD(BAUD)) u_rx (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx       (i_rx),
    .o_valid    (rx_valid),
    .o_data     (rx_data),
    .o_frame_err(rx_ferr)
  );

  ld_state_e              state_q, state_d;
  logic [PROG_ADDR_W-1:0] len_q, len_d;
  logic [PROG_ADDR_W-1:0] idx_q, idx_d;
  logic [PROG_DATA_W-1:0] sum_q, sum_d;
  logic [PROG_ADDR_W-1:0] count_q, count_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   we_q, we_d;
  logic [PROG_ADDR_W-1:0] addr_q, addr_d;
  logic [PROG_DATA_W-1:0] din_q, din_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   tmo_hit;
  logic [PROG_ADDR_W-1:0] len_lo_val;

  assign tmo_hit    = (tmo_q == TW'(TMO_CYC));
  assign len_lo_val = {len_q[11:8], rx_data};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= LD_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;

    // Gap counter saturates at the limit; any received byte restarts it.
    if (state_q == LD_IDLE || rx_valid) begin
      tmo_d = '0;
    end else if (!tmo_hit) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = tmo_q;
    end

    if (state_q != LD_IDLE && (rx_ferr || (tmo_hit && !rx_valid))) begin
      err_d   = 1'b1;
      busy_d  = 1'b0;
      state_d = LD_IDLE;
    end else begin
      case (state_q)
        LD_IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            busy_d  = 1'b1;
            err_d   = 1'b0;
            count_d = '0;
            sum_d   = '0;
            state_d = LD_LEN_HI;
          end
        end
        LD_LEN_HI: begin
          if (rx_valid) begin
            if (rx_data[7:4] != 4'h0) begin
              err_d   = 1'b1;
              busy_d  = 1'b0;
              state_d = LD_IDLE;
            end else begin
              len_d   = {rx_data[3:0], 8'h00};
              state_d = LD_LEN_LO;
            end
          end
        end
        LD_LEN_LO: begin
          if (rx_valid) begin
            len_d   = len_lo_val;
            idx_d   = '0;
            state_d = (len_lo_val == '0) ? LD_CSUM : LD_DATA;
          end
        end
        LD_DATA: begin
          if (rx_valid) begin
            we_d    = 1'b1;
            addr_d  = idx_q;
            din_d   = rx_data;
            idx_d   = idx_q + 1'b1;
            count_d = count_q + 1'b1;
            sum_d   = sum_q + rx_data;
            if (idx_q == len_q - 1'b1) begin
              state_d = LD_CSUM;
            end
          end
        end
        LD_CSUM: begin
          if (rx_valid) begin
            if (rx_data == sum_q) begin
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            busy_d  = 1'b0;
            state_d = LD_IDLE;
          end
        end
        default: state_d = LD_IDLE;
      endcase
    end
  end

  assign o_mem.we   = we_q;
  assign o_mem.addr = addr_q;
  assign o_mem.din  = din_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = err_q;
  assign o_count    = count_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the 4096x8 program memory: receives a framed program image over a UART line and writes it byte-by-byte into the memory's write port, starting at address 0x000.
- Sits between the board RX pin and the program RAM that the display/fetch logic reads through its 12-bit address / 8-bit data port.
- Reports progress and status so the top level can hold off fetches while loading.

Parameters:
- FREQ, 27_000_000, i_clk frequency in Hz.
- BAUD, 115_200, UART bit rate (8N1).
- TIMEOUT_MS, 10, maximum inter-byte gap inside a frame before abort.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rx  in  1  UART serial input, idle high, asynchronous to i_clk.
- o_mem_we  out  1  one-cycle write strobe to program memory.
- o_mem_addr  out  12  write address.
- o_mem_din  out  8  write data.
- o_busy  out  1  high while a frame is in progress.
- o_done  out  1  one-cycle pulse on good checksum.
- o_error  out  1  sticky error flag.
- o_count  out  12  bytes written in the current/last frame.

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0; FSM in IDLE; UART RX idle; timeout counter cleared.
- RX front end: 2-FF synchroniser on i_rx. Start bit is detected on a falling edge and confirmed low at mid-bit; if it is high there, it is ignored.
- Divisor is FREQ/BAUD, integer truncated (234 at defaults). Eight data bits are sampled mid-bit, LSB first.
- Stop bit sampled 0: framing error; byte discarded.
- On a good stop bit, rx_valid is pulsed for 1 cycle with rx_data.
- Frame format: 0xA5 sync, LEN_HI, LEN_LO, N data bytes, CSUM.
  - N = {LEN_HI[3:0], LEN_LO}, range 0..4095.
  - CSUM = 8-bit wrapping sum of the data bytes.
- FSM states: IDLE -> LEN_HI -> LEN_LO -> DATA -> CSUM -> IDLE.
  - IDLE: a byte other than 0xA5 is dropped silently. On 0xA5: o_busy<=1, o_error<=0, o_count<=0, sum<=0.
  - LEN_HI: LEN_HI[7:4] != 0 sets o_error and returns to IDLE.
  - LEN_LO: N==0 goes directly to CSUM. Otherwise go to DATA with index=0.
  - DATA: each rx_valid drives, the next cycle, o_mem_we=1, o_mem_addr=index, o_mem_din=byte. index, o_count and sum update at the same time. After byte N-1, go to CSUM.
  - CSUM: match gives o_done pulse for 1 cycle. Mismatch sets o_error. Either way o_busy<=0 and the FSM returns to IDLE.
- Write latency: exactly 1 cycle from rx_valid to o_mem_we. At most one write per received byte; no write occurs in any other state.
- Timeout: in any non-IDLE state, an inter-byte gap exceeding TIMEOUT_MS*FREQ/1000 cycles sets o_error, clears o_busy and returns to IDLE. Bytes already written stay in memory.
- Framing error outside IDLE: o_error set, return to IDLE. Framing error in IDLE is ignored.
- Address width: index is 12 bits and cannot wrap, because N is at most 4095.
- Simultaneous events: rx_valid and timeout expiry in the same cycle resolve in favour of rx_valid. The timeout counter clears on every rx_valid.
- Reset mid-frame: immediate abort; no o_done; memory contents undefined beyond the writes already issued.
- o_error stays high until the next 0xA5 is accepted in IDLE, or until reset.

Decomposition:
- Shared package constants:
  - SYNC_BYTE=8'hA5.
  - Loader state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM).
  - PROG_ADDR_W=12, PROG_DATA_W=8, shared with the fetch side.
- One sub-module: uart_rx (FREQ, BAUD). Ports: i_clk, i_rst_n, i_rx, o_valid, o_data[7:0], o_frame_err. Contains the synchroniser and bit timing.
- The framing FSM, checksum and write port live in prog_loader.

Test Plan:
- Frame A5 00 03 11 22 33 66 -> writes (000,11) (001,22) (002,33), each 1 cycle after its rx_valid; then o_done pulse, o_count=3, o_error=0, o_busy low.
- Frame A5 00 02 10 20 00 (bad CSUM, expected 0x30) -> 2 writes, then o_error=1, no o_done; the next A5 clears o_error.
- Frame A5 00 00 00 -> no writes; o_done pulse; o_count=0. Frame A5 10 ... -> o_error=1 after LEN_HI, no writes.
- Frame A5 0F FF with 4095 bytes of 0x01, CSUM FF -> last write at addr FFE; o_done; o_count=FFF.
- Frame A5 00 04 01 02 then idle line for 11 ms -> 2 writes, o_error=1, o_busy=0. Repeat with the stop bit forced 0 on byte 3 -> o_error, back in IDLE.
- Assert i_rst_n low mid-DATA -> outputs 0 immediately and asynchronously; after release, garbage bytes 55 AA are ignored, and the next valid frame loads normally.
